// File: rtl/imuldiv_pkg.sv
// imuldiv_pkg -- shared CPU constants for the HI/LO multiply/divide unit:
// data width, op-code width and the op-code enumeration that decode drives
// onto i_op, plus the iteration count of the shift/add engine.
package imuldiv_pkg;

  localparam int CPU_DATA_WIDTH  = 32;
  localparam int CPU_IMDOP_WIDTH = 3;

  // Op codes presented on i_op by the decode stage.
  typedef enum logic [CPU_IMDOP_WIDTH-1:0] {
    IMD_NONE  = 3'd0,
    IMD_MULT  = 3'd1,
    IMD_MULTU = 3'd2,
    IMD_DIV   = 3'd3,
    IMD_DIVU  = 3'd4,
    IMD_MTHI  = 3'd5,
    IMD_MTLO  = 3'd6
  } imd_op_e;

  localparam int              CNT_WIDTH  = 6;
  localparam logic [CNT_WIDTH-1:0] ITER_COUNT = 6'd32;

endpackage

// File: rtl/imuldiv_step.sv
// imuldiv_step -- one combinational iteration of the shared 33-bit
// add/subtract-and-shift engine.
//   MUL: {hi,lo} = ({1'b0,hi} + (lo[0] ? b : 0)) shifted right by one,
//        the multiplier drains out of lo while the product fills in.
//   DIV (only with CPU_IMULDIV_DIV_EN): restoring step, {hi,lo[31]} - b;
//        keep the difference when it does not borrow and shift the
//        quotient bit into lo.
module imuldiv_step
  import imuldiv_pkg::*;
(
`ifdef CPU_IMULDIV_DIV_EN
  input  logic                      i_div,
`endif
  input  logic [CPU_DATA_WIDTH-1:0] i_hi,
  input  logic [CPU_DATA_WIDTH-1:0] i_lo,
  input  logic [CPU_DATA_WIDTH-1:0] i_b,
  output logic [CPU_DATA_WIDTH-1:0] o_hi,
  output logic [CPU_DATA_WIDTH-1:0] o_lo
);

`ifdef CPU_IMULDIV_DIV_EN
  logic [CPU_DATA_WIDTH:0]   w_a;
  logic [CPU_DATA_WIDTH:0]   w_b;
  logic                      w_cin;
  logic [CPU_DATA_WIDTH+1:0] w_sum;

  // Shared adder: add for multiply, a + ~b + 1 for divide (bit 33 = no borrow).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    w_a   = {1'b0, i_hi};
    w_b   = i_lo[0] ? {1'b0, i_b} : '0;
    w_cin = 1'b0;
    if (i_div) begin
      w_a   = {i_hi, i_lo[CPU_DATA_WIDTH-1]};
      w_b   = ~{1'b0, i_b};
      w_cin = 1'b1;
    end
    w_sum = {1'b0, w_a} + {1'b0, w_b} + {{(CPU_DATA_WIDTH+1){1'b0}}, w_cin};
    o_hi  = w_sum[CPU_DATA_WIDTH:1];
    o_lo  = {w_sum[0], i_lo[CPU_DATA_WIDTH-1:1]};
    if (i_div) begin
      if (w_sum[CPU_DATA_WIDTH+1]) begin
        o_hi = w_sum[CPU_DATA_WIDTH-1:0];
        o_lo = {i_lo[CPU_DATA_WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_a[CPU_DATA_WIDTH-1:0];
        o_lo = {i_lo[CPU_DATA_WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic [CPU_DATA_WIDTH:0] w_sum;

  // Multiply-only build: conditional add of the multiplicand, then shift.
  always_comb begin
    w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    o_hi  = w_sum[CPU_DATA_WIDTH:1];
    o_lo  = {w_sum[0], i_lo[CPU_DATA_WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/imuldiv.sv
// imuldiv -- iterative HI/LO multiply/divide unit. MULT/MULTU (and DIV/DIVU
// when CPU_IMULDIV_DIV_EN is defined) run 32 iterations on operand
// magnitudes and write HI/LO with sign fix-up at the last edge; MTHI/MTLO
// write in one edge. o_busy stalls the pipeline; i_flush aborts; rst is
// synchronous, active-high and dominates everything.
module imuldiv
  import imuldiv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CPU_IMDOP_WIDTH-1:0] i_op,
  input  logic [CPU_DATA_WIDTH-1:0]  i_rs,
  input  logic [CPU_DATA_WIDTH-1:0]  i_rt,
  input  logic                       i_flush,
  output logic [CPU_DATA_WIDTH-1:0]  o_hi,
  output logic [CPU_DATA_WIDTH-1:0]  o_lo,
  output logic                       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef CPU_IMULDIV_DIV_EN
    , ST_DIV = 2'd2
`endif
  } state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [CPU_DATA_WIDTH-1:0]   r_acc_hi;
  logic [CPU_DATA_WIDTH-1:0]   r_acc_lo;
  logic [CPU_DATA_WIDTH-1:0]   r_b;
  logic                        r_neg_res;
  logic [CPU_DATA_WIDTH-1:0]   r_hi;
  logic [CPU_DATA_WIDTH-1:0]   r_lo;
`ifdef CPU_IMULDIV_DIV_EN
  logic                        r_neg_rem;
  logic                        r_dz;
`endif

  logic                        w_idle;
  logic                        w_last;
  logic                        w_start_mul;
  logic                        w_start_div;
  logic                        w_signed;
  logic                        w_rs_neg;
  logic                        w_rt_neg;
  logic [CPU_DATA_WIDTH-1:0]   w_rs_mag;
  logic [CPU_DATA_WIDTH-1:0]   w_rt_mag;
  logic [CPU_DATA_WIDTH-1:0]   w_step_hi;
  logic [CPU_DATA_WIDTH-1:0]   w_step_lo;
  logic [2*CPU_DATA_WIDTH-1:0] w_prod;
  logic [CPU_DATA_WIDTH-1:0]   w_res_hi;
  logic [CPU_DATA_WIDTH-1:0]   w_res_lo;

  assign w_idle = (r_state == ST_IDLE);
  assign w_last = (r_cnt == 6'd1);
  assign o_busy = !w_idle;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // Decode which iterative op would start this cycle and its operand signs.
  always_comb begin
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_signed    = 1'b0;
    if (w_idle && !i_flush) begin
      case (i_op)
        IMD_MULT:  begin w_start_mul = 1'b1; w_signed = 1'b1; end
        IMD_MULTU: w_start_mul = 1'b1;
`ifdef CPU_IMULDIV_DIV_EN
        IMD_DIV:   begin w_start_div = 1'b1; w_signed = 1'b1; end
        IMD_DIVU:  w_start_div = 1'b1;
`endif
        default:   ;
      endcase
    end
    w_rs_neg = w_signed & i_rs[CPU_DATA_WIDTH-1];
    w_rt_neg = w_signed & i_rt[CPU_DATA_WIDTH-1];
    w_rs_mag = w_rs_neg ? (~i_rs + 32'd1) : i_rs;
    w_rt_mag = w_rt_neg ? (~i_rt + 32'd1) : i_rt;
  end

  imuldiv_step u_step (
`ifdef CPU_IMULDIV_DIV_EN
    .i_div (r_state == ST_DIV),
`endif
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  // Sign fix-up of the final iteration's result before it lands in HI/LO.
  always_comb begin
    w_prod   = {w_step_hi, w_step_lo};
    w_prod   = r_neg_res ? (~w_prod + 64'd1) : w_prod;
    w_res_hi = w_prod[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH];
    w_res_lo = w_prod[CPU_DATA_WIDTH-1:0];
`ifdef CPU_IMULDIV_DIV_EN
    if (r_state == ST_DIV) begin
      // With a zero divisor the remainder path returns the dividend magnitude,
      // so restoring its sign hands back i_rs exactly.
      w_res_hi = r_neg_rem ? (~w_step_hi + 32'd1) : w_step_hi;
      if (r_dz)           w_res_lo = '1;
      else if (r_neg_res) w_res_lo = ~w_step_lo + 32'd1;
      else                w_res_lo = w_step_lo;
    end
`endif
  end

  // Next-state logic: start from IDLE, leave on the last iteration or a flush.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mul) w_state_next = ST_MUL;
`ifdef CPU_IMULDIV_DIV_EN
        else if (w_start_div) w_state_next = ST_DIV;
`endif
      end
      default: begin
        if (i_flush || w_last) w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath: operand latch on start, one engine step per busy cycle,
  // HI/LO commit on the last step or on MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_b       <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef CPU_IMULDIV_DIV_EN
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
`endif
    end else if (w_idle) begin
      if (w_start_mul || w_start_div) begin
        r_cnt     <= ITER_COUNT;
        r_acc_hi  <= '0;
        r_acc_lo  <= w_rs_mag;
        r_b       <= w_rt_mag;
        r_neg_res <= w_rs_neg ^ w_rt_neg;
`ifdef CPU_IMULDIV_DIV_EN
        r_neg_rem <= w_rs_neg;
        r_dz      <= (i_rt == '0);
`endif
      end else if (!i_flush && (i_op == IMD_MTHI)) begin
        r_hi <= i_rs;
      end else if (!i_flush && (i_op == IMD_MTLO)) begin
        r_lo <= i_rs;
      end
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_cnt    <= r_cnt - 6'd1;
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

endmodule

// File: tb/tb_imuldiv.sv
// tb_imuldiv -- self-checking bench for imuldiv. Expected HI/LO/busy come
// from a behavioural model using native SV arithmetic, pushed onto a
// scoreboard when an op is issued and popped when the DUT finishes.
// DIV coverage follows CPU_IMULDIV_DIV_EN, matching the RTL build.
module tb_imuldiv;
  import imuldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  i_op;
  logic [31:0] i_rs;
  logic [31:0] i_rt;
  logic        i_flush;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  imuldiv dut (
    .clk     (clk),
    .rst     (rst),
    .i_op    (i_op),
    .i_rs    (i_rs),
    .i_rt    (i_rt),
    .i_flush (i_flush),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] hi,
                                 input logic [31:0] lo);
    exp_t               e;
    logic signed [63:0] sa, sb_;
    logic        [63:0] p;
    logic signed [31:0] a, b, q, r;
    e.hi = hi; e.lo = lo; e.busy = 1'b0;
    a = rs; b = rt;
    case (op)
      IMD_MULT: begin
        sa = {{32{rs[31]}}, rs};
        sb_ = {{32{rt[31]}}, rt};
        p = sa * sb_;
        e.hi = p[63:32]; e.lo = p[31:0]; e.busy = 1'b1;
      end
      IMD_MULTU: begin
        p = {32'd0, rs} * {32'd0, rt};
        e.hi = p[63:32]; e.lo = p[31:0]; e.busy = 1'b1;
      end
`ifdef CPU_IMULDIV_DIV_EN
      IMD_DIV: begin
        e.busy = 1'b1;
        if (rt == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = rs;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          q = a / b; r = a % b;
          e.lo = q; e.hi = r;
        end
      end
      IMD_DIVU: begin
        e.busy = 1'b1;
        if (rt == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = rs;
        end else begin
          e.lo = rs / rt; e.hi = rs % rt;
        end
      end
`endif
      IMD_MTHI: e.hi = rs;
      IMD_MTLO: e.lo = rs;
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op, hammer i_op with MTLO while busy (must be ignored),
  // then compare busy length and HI/LO against the scoreboard head.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int   n;
    sb.push_back(model(op, rs, rt, m_hi, m_lo));
    i_op = op; i_rs = rs; i_rt = rt;
    @(posedge clk); #1;
    i_op = IMD_NONE; i_rs = ~rs; i_rt = ~rt;
    n = 0;
    while (o_busy && n < 40) begin
      i_op = IMD_MTLO; i_rs = 32'hDEAD_BEEF;
      n++;
      @(posedge clk); #1;
    end
    i_op = IMD_NONE;
    e = sb.pop_front();
    check({tag, "_busy_cycles"}, 64'(n), e.busy ? 64'd32 : 64'd0);
    check({tag, "_hi"}, {32'd0, o_hi}, {32'd0, e.hi});
    check({tag, "_lo"}, {32'd0, o_lo}, {32'd0, e.lo});
    m_hi = e.hi; m_lo = e.lo;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;
    rst = 1'b1; i_op = IMD_NONE; i_rs = '0; i_rt = '0; i_flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", {32'd0, o_hi}, 64'd0);
    check("reset_lo", {32'd0, o_lo}, 64'd0);
    check("reset_busy", {63'd0, o_busy}, 64'd0);
    rst = 1'b0;

    // MTHI then MTLO on consecutive cycles.
    run_op("mthi", IMD_MTHI, 32'h1234_5678, 32'h0);
    run_op("mtlo", IMD_MTLO, 32'h9ABC_DEF0, 32'h0);

    // Multiply corner cases, issued back to back.
    run_op("multu_max", IMD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m3x7", IMD_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("mult_min", IMD_MULT, 32'h8000_0000, 32'h8000_0000);

`ifdef CPU_IMULDIV_DIV_EN
    run_op("div_m7d2", IMD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_dz", IMD_DIVU, 32'd100, 32'd0);
    run_op("div_ovf", IMD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_dz_neg", IMD_DIV, 32'hFFFF_FF9C, 32'd0);
    run_op("divu_big", IMD_DIVU, 32'hFFFF_FFFF, 32'd7);
`else
    run_op("divu_off", IMD_DIVU, 32'd10, 32'd3);
    run_op("div_off", IMD_DIV, 32'd10, 32'd3);
`endif

    // Random iterative ops.
    for (int k = 0; k < 8; k++) begin
      rop = 3'(IMD_MULT + $urandom_range(0, 3));
      rrs = $urandom;
      rrt = $urandom;
      run_op($sformatf("rand%0d", k), rop, rrs, rrt);
    end

    // Flush at cycle 10 of a MULT: back to IDLE, HI/LO untouched.
    i_op = IMD_MULT; i_rs = 32'd5; i_rt = 32'd6;
    @(posedge clk); #1;
    i_op = IMD_NONE;
    check("flush_started", {63'd0, o_busy}, 64'd1);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_busy", {63'd0, o_busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi", {32'd0, o_hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, o_lo}, {32'd0, m_lo});

    // Flush in IDLE suppresses simultaneous ops.
    i_op = IMD_MULT; i_flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_mult_busy", {63'd0, o_busy}, 64'd0);
    i_op = IMD_MTHI; i_rs = 32'hCAFE_F00D;
    @(posedge clk); #1;
    i_op = IMD_NONE; i_flush = 1'b0;
    check("idle_flush_mthi_hi", {32'd0, o_hi}, {32'd0, m_hi});

    // Reset mid-MULT with op and flush also asserted.
    i_op = IMD_MULT; i_rs = 32'd11; i_rt = 32'd13;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_hi", {32'd0, o_hi}, 64'd0);
    check("rst_mid_lo", {32'd0, o_lo}, 64'd0);
    check("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    rst = 1'b0; i_flush = 1'b0; i_op = IMD_NONE;
    m_hi = '0; m_lo = '0;

    run_op("post_rst_multu", IMD_MULTU, 32'd7, 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
